// File: rtl/tri_hit_reducer.sv
// Multi-lane nearest-hit reducer for triangle batches, with an any-hit (shadow ray) early-done mode.
// Optional hit statistics output is enabled by defining HIT_REDUCER_STATS_EN.
module tri_hit_reducer #(
    parameter int unsigned             LANES = 4,
    parameter int unsigned             T_W   = 32,
    parameter int unsigned             IDX_W = 32,
    parameter logic signed [T_W-1:0]   MIN_T = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [31:0]              i_tri_cnt,
    input  logic                     i_any_hit,
    input  logic [LANES-1:0]         i_valid,
    input  logic [LANES-1:0]         i_hit,
    input  logic [LANES*T_W-1:0]     i_t,
    input  logic [LANES*IDX_W-1:0]   i_idx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_hit,
    output logic [T_W-1:0]           o_t,
    output logic [IDX_W-1:0]         o_tri_index
`ifdef HIT_REDUCER_STATS_EN
    ,
    output logic [31:0]              o_hit_cnt
`endif
);

    localparam int unsigned ACC_W = $clog2(LANES + 1);
    localparam logic [T_W-1:0] T_MAX = {1'b0, {(T_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        remaining_q, remaining_d;
    logic               any_mode_q, any_mode_d;

    // Stage 1 registers: per-cycle winner and acceptance summary
    logic               s1_win_q;
    logic               s1_last_q;
    logic [T_W-1:0]     s1_t_q;
    logic [IDX_W-1:0]   s1_idx_q;

    logic               done_d, hit_d, busy_d;
    logic [T_W-1:0]     t_d;
    logic [IDX_W-1:0]   idx_d;

    logic [ACC_W-1:0]   acc_cnt_c;
    logic [ACC_W-1:0]   qual_cnt_c;
    logic               win_found_c;
    logic [T_W-1:0]     win_t_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic [T_W-1:0]     lane_t_c;
    logic               last_c;

`ifdef HIT_REDUCER_STATS_EN
    logic [ACC_W-1:0]   s1_qcnt_q;
    logic [31:0]        hit_cnt_d;
    logic [32:0]        hit_cnt_sum_c;
`endif

    // Accept lowest valid lanes up to the unaccepted count; pick min-t qualifying lane
    always_comb begin
        acc_cnt_c   = '0;
        qual_cnt_c  = '0;
        win_found_c = 1'b0;
        win_t_c     = T_MAX;
        win_idx_c   = '0;
        lane_t_c    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_t_c = i_t[k*T_W +: T_W];
            if ((state_q != ST_IDLE) && i_valid[k] && (32'(acc_cnt_c) < remaining_q)) begin
                acc_cnt_c = acc_cnt_c + ACC_W'(1);
                if (i_hit[k] && ($signed(lane_t_c) > MIN_T)) begin
                    qual_cnt_c = qual_cnt_c + ACC_W'(1);
                    if (!win_found_c || ($signed(lane_t_c) < $signed(win_t_c))) begin
                        win_found_c = 1'b1;
                        win_t_c     = lane_t_c;
                        win_idx_c   = i_idx[k*IDX_W +: IDX_W];
                    end
                end
            end
        end
        last_c = (acc_cnt_c != '0) && (32'(acc_cnt_c) == remaining_q);
    end

    // Next-state and result update (stage 2)
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        any_mode_d  = any_mode_q;
        done_d      = 1'b0;
        hit_d       = o_hit;
        t_d         = o_t;
        idx_d       = o_tri_index;
`ifdef HIT_REDUCER_STATS_EN
        hit_cnt_d     = o_hit_cnt;
        hit_cnt_sum_c = {1'b0, o_hit_cnt} + 33'(s1_qcnt_q);
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    hit_d = 1'b0;
                    t_d   = T_MAX;
                    idx_d = '0;
`ifdef HIT_REDUCER_STATS_EN
                    hit_cnt_d = '0;
`endif
                    if (i_tri_cnt == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        remaining_d = i_tri_cnt;
                        any_mode_d  = i_any_hit;
                    end
                end
            end
            ST_RUN: begin
                remaining_d = remaining_q - 32'(acc_cnt_c);
                if (s1_win_q) begin
                    hit_d = 1'b1;
                    // first hit always lands, so a hit at exactly T_MAX still records its index
                    if (!o_hit || ($signed(s1_t_q) < $signed(o_t))) begin
                        t_d   = s1_t_q;
                        idx_d = s1_idx_q;
                    end
                end
`ifdef HIT_REDUCER_STATS_EN
                hit_cnt_d = hit_cnt_sum_c[32] ? 32'hFFFF_FFFF : hit_cnt_sum_c[31:0];
`endif
                if (s1_last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (any_mode_q && s1_win_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                remaining_d = remaining_q - 32'(acc_cnt_c);
`ifdef HIT_REDUCER_STATS_EN
                hit_cnt_d = hit_cnt_sum_c[32] ? 32'hFFFF_FFFF : hit_cnt_sum_c[31:0];
`endif
                if (s1_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            remaining_q <= '0;
            any_mode_q  <= 1'b0;
            s1_win_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_t_q      <= '0;
            s1_idx_q    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_hit       <= 1'b0;
            o_t         <= T_MAX;
            o_tri_index <= '0;
`ifdef HIT_REDUCER_STATS_EN
            s1_qcnt_q   <= '0;
            o_hit_cnt   <= '0;
`endif
        end else begin
            remaining_q <= remaining_d;
            any_mode_q  <= any_mode_d;
            s1_win_q    <= win_found_c;
            s1_last_q   <= last_c;
            s1_t_q      <= win_t_c;
            s1_idx_q    <= win_idx_c;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_hit       <= hit_d;
            o_t         <= t_d;
            o_tri_index <= idx_d;
`ifdef HIT_REDUCER_STATS_EN
            s1_qcnt_q   <= qual_cnt_c;
            o_hit_cnt   <= hit_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tri_hit_reducer.sv
// Scoreboard bench for tri_hit_reducer: directed scenarios plus random batches against a batch-level model.
module tb_tri_hit_reducer;

    localparam int LANES = 4;
    localparam int T_W   = 32;
    localparam int IDX_W = 32;
    localparam int MAXC  = 64;
    localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;

    logic                   i_clk = 1'b0;
    logic                   i_rstn = 1'b0;
    logic                   i_start = 1'b0;
    logic [31:0]            i_tri_cnt = '0;
    logic                   i_any_hit = 1'b0;
    logic [LANES-1:0]       i_valid = '0;
    logic [LANES-1:0]       i_hit = '0;
    logic [LANES*T_W-1:0]   i_t = '0;
    logic [LANES*IDX_W-1:0] i_idx = '0;
    logic                   o_busy, o_done, o_hit;
    logic [T_W-1:0]         o_t;
    logic [IDX_W-1:0]       o_tri_index;
`ifdef HIT_REDUCER_STATS_EN
    logic [31:0]            o_hit_cnt;
`endif

    tri_hit_reducer #(.LANES(LANES), .T_W(T_W), .IDX_W(IDX_W), .MIN_T('0)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_tri_cnt(i_tri_cnt),
        .i_any_hit(i_any_hit), .i_valid(i_valid), .i_hit(i_hit), .i_t(i_t), .i_idx(i_idx),
        .o_busy(o_busy), .o_done(o_done), .o_hit(o_hit), .o_t(o_t), .o_tri_index(o_tri_index)
`ifdef HIT_REDUCER_STATS_EN
        , .o_hit_cnt(o_hit_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic hit; logic [31:0] t; logic [31:0] idx; } exp_done_t;
    typedef struct { int cyc; int hc; } exp_busy_t;
    exp_done_t done_q[$];
    exp_busy_t busy_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expectations whenever the DUT signals done or drops busy
    logic prev_busy = 1'b0;
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            prev_busy = 1'b0;
        end else begin
            if (o_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    exp_done_t e;
                    e = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_hit", 64'(o_hit), 64'(e.hit));
                    chk("done_t", 64'(o_t), 64'(e.t));
                    chk("done_idx", 64'(o_tri_index), 64'(e.idx));
                end
            end
            if (prev_busy && !o_busy) begin
                if (busy_q.size() == 0) begin
                    chk("unexpected_busy_fall", 64'(1), 64'(0));
                end else begin
                    exp_busy_t b;
                    b = busy_q.pop_front();
                    chk("busy_fall_cycle", 64'(cyc), 64'(b.cyc));
`ifdef HIT_REDUCER_STATS_EN
                    chk("hit_cnt", 64'(o_hit_cnt), 64'(b.hc));
`endif
                end
            end
            prev_busy = o_busy;
        end
    end

    // Batch stimulus, one entry per result cycle
    logic [LANES-1:0] st_valid [MAXC];
    logic [LANES-1:0] st_hit   [MAXC];
    logic [31:0]      st_t     [MAXC][LANES];
    logic [31:0]      st_idx   [MAXC][LANES];
    int               st_n;

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            st_valid[c] = '0;
            st_hit[c]   = '0;
            for (int k = 0; k < LANES; k++) begin
                st_t[c][k]   = '0;
                st_idx[c][k] = '0;
            end
        end
        st_n = 0;
    endtask

    task automatic drive_lanes(input logic [LANES-1:0] v, input logic [LANES-1:0] h, input int c);
        logic [LANES*T_W-1:0]   pt;
        logic [LANES*IDX_W-1:0] pi;
        pt = '0;
        pi = '0;
        for (int k = 0; k < LANES; k++) begin
            pt[k*T_W +: T_W]     = st_t[c][k];
            pi[k*IDX_W +: IDX_W] = st_idx[c][k];
        end
        i_valid = v;
        i_hit   = h;
        i_t     = pt;
        i_idx   = pi;
    endtask

    task automatic drive_garbage();
        logic [LANES*T_W-1:0] pt;
        for (int k = 0; k < LANES; k++) pt[k*T_W +: T_W] = 32'($urandom_range(1, 5)) << 12;
        i_valid = LANES'($urandom);
        i_hit   = LANES'($urandom);
        i_t     = pt;
        i_idx   = {LANES{$urandom}};
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 40 && (done_q.size() > 0 || busy_q.size() > 0); w++) @(posedge i_clk);
        if (done_q.size() > 0 || busy_q.size() > 0) begin
            chk("drain_timeout", 64'(done_q.size() + busy_q.size()), 64'(0));
            done_q.delete();
            busy_q.delete();
        end
    endtask

    task automatic run_batch(input logic [31:0] cnt, input logic any, input bit poke_start);
        logic [31:0] qt[$];
        logic [31:0] qi[$];
        int          qc[$];
        int          rem, hc, last_rc, done_rc, s;
        logic        found;
        logic [31:0] bt, bi;
        exp_done_t   ed;
        exp_busy_t   eb;

        // pad with all-valid, no-hit cycles so every batch finishes
        for (int c = st_n; c < MAXC; c++) begin
            st_valid[c] = '1;
            st_hit[c]   = '0;
        end

        // batch-level model: ordered list of accepted qualifying hits
        rem = int'(cnt); hc = 0; last_rc = -1;
        for (int rc = 0; rc < MAXC && rem > 0; rc++) begin
            int taken = 0;
            for (int k = 0; k < LANES; k++) begin
                if (st_valid[rc][k] && taken < rem) begin
                    taken++;
                    if (st_hit[rc][k] && $signed(st_t[rc][k]) > 0) begin
                        hc++;
                        qt.push_back(st_t[rc][k]);
                        qi.push_back(st_idx[rc][k]);
                        qc.push_back(rc);
                    end
                end
            end
            rem -= taken;
            if (rem == 0) last_rc = rc;
        end
        found = 1'b0; bt = T_MAX; bi = '0; done_rc = last_rc;
        for (int i = 0; i < qt.size(); i++) begin
            if (any && found && qc[i] != qc[0]) break;
            if (!found || $signed(qt[i]) < $signed(bt)) begin
                found = 1'b1; bt = qt[i]; bi = qi[i];
            end
        end
        if (any && found) done_rc = qc[0];

        @(posedge i_clk); #1;
        s = cyc;
        i_start = 1'b1; i_tri_cnt = cnt; i_any_hit = any;
        drive_garbage();
        if (cnt == 0) begin
            ed.cyc = s + 1; ed.hit = 1'b0; ed.t = T_MAX; ed.idx = '0;
            done_q.push_back(ed);
            @(posedge i_clk); #1;
            i_start = 1'b0;
            @(negedge i_clk);
            chk("zero_cnt_busy", 64'(o_busy), 64'(0));
        end else begin
            ed.cyc = s + 3 + done_rc; ed.hit = found; ed.t = bt; ed.idx = bi;
            done_q.push_back(ed);
            eb.cyc = s + 3 + last_rc; eb.hc = hc;
            busy_q.push_back(eb);
            for (int rc = 0; rc <= last_rc; rc++) begin
                @(posedge i_clk); #1;
                i_start   = poke_start && (rc == 1);
                i_tri_cnt = $urandom_range(1, 9);
                i_any_hit = 1'($urandom);
                drive_lanes(st_valid[rc], st_hit[rc], rc);
            end
        end
        for (int g = 0; g < 2; g++) begin
            @(posedge i_clk); #1;
            i_start = 1'b0;
            drive_garbage();
        end
        @(posedge i_clk); #1;
        i_valid = '0; i_hit = '0;
        wait_drain();
    endtask

    task automatic set_lane(input int c, input int k, input logic v, input logic h,
                            input logic [31:0] t, input logic [31:0] idx);
        st_valid[c][k] = v;
        st_hit[c][k]   = h;
        st_t[c][k]     = t;
        st_idx[c][k]   = idx;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_hit", 64'(o_hit), 64'(0));
        chk("rst_t", 64'(o_t), 64'(T_MAX));
        chk("rst_idx", 64'(o_tri_index), 64'(0));
        i_rstn = 1'b1;

        // reset in the middle of a batch after 3 of 8 results
        clear_stim();
        @(posedge i_clk); #1;
        i_start = 1'b1; i_tri_cnt = 32'd8; i_any_hit = 1'b0;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) set_lane(0, k, 1'b1, 1'b1, 32'h0001_0000 + 32'(k), 32'(20 + k));
        drive_lanes(st_valid[0], st_hit[0], 0);
        @(posedge i_clk); #1;
        i_valid = '0; i_hit = '0;
        i_rstn = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("midrst_busy", 64'(o_busy), 64'(0));
        chk("midrst_t", 64'(o_t), 64'(T_MAX));
        chk("midrst_hit", 64'(o_hit), 64'(0));
        chk("midrst_done", 64'(o_done), 64'(0));
        i_rstn = 1'b1;
        clear_stim();
        set_lane(0, 2, 1'b1, 1'b1, 32'h0004_0000, 32'd33);
        st_valid[0] = '1;
        st_n = 1;
        run_batch(32'd4, 1'b0, 1'b0);

        // closest, lane tie on 2.0 goes to lower lane
        clear_stim();
        set_lane(0, 0, 1'b1, 1'b1, 32'h0005_0000, 32'd7);
        set_lane(0, 1, 1'b1, 1'b1, 32'h0002_0000, 32'd6);
        set_lane(0, 2, 1'b1, 1'b1, 32'h0002_0000, 32'd5);
        set_lane(0, 3, 1'b1, 1'b1, 32'h0009_0000, 32'd4);
        st_valid[1] = '1;
        st_n = 2;
        run_batch(32'd8, 1'b0, 1'b0);

        // excess valids beyond count are dropped
        clear_stim();
        st_valid[0] = '1;
        set_lane(1, 0, 1'b1, 1'b1, 32'h0001_0000, 32'd11);
        set_lane(1, 1, 1'b1, 1'b1, 32'h0000_8000, 32'd12);
        st_valid[1] = '1;
        st_n = 2;
        run_batch(32'd5, 1'b0, 1'b0);

        // any-hit: first hit frozen, later smaller hits ignored, drain to end
        clear_stim();
        for (int c = 0; c < 3; c++) st_valid[c] = '1;
        set_lane(0, 1, 1'b1, 1'b1, 32'h0003_0000, 32'd40);
        set_lane(1, 2, 1'b1, 1'b1, 32'h0001_0000, 32'd41);
        set_lane(2, 0, 1'b1, 1'b1, 32'h0000_8000, 32'd42);
        st_n = 3;
        run_batch(32'd12, 1'b1, 1'b1);

        // t=0 and negative t do not qualify; then an empty batch
        clear_stim();
        set_lane(0, 0, 1'b1, 1'b1, 32'h0000_0000, 32'd50);
        set_lane(0, 1, 1'b1, 1'b1, 32'hFFFF_0000, 32'd51);
        st_valid[0] = '1;
        st_n = 1;
        run_batch(32'd4, 1'b0, 1'b0);
        clear_stim();
        run_batch(32'd0, 1'b0, 1'b0);

        // equal t across cycles keeps the earlier hit
        clear_stim();
        set_lane(0, 0, 1'b1, 1'b1, 32'h0002_0000, 32'd9);
        set_lane(1, 0, 1'b1, 1'b1, 32'h0002_0000, 32'd3);
        st_valid[0] = '1;
        st_valid[1] = '1;
        st_n = 2;
        run_batch(32'd8, 1'b0, 1'b0);

        // random batches
        for (int b = 0; b < 40; b++) begin
            logic [31:0] cnt;
            clear_stim();
            cnt = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            for (int c = 0; c < 24; c++) begin
                st_valid[c] = LANES'($urandom);
                st_hit[c]   = LANES'($urandom);
                for (int k = 0; k < LANES; k++) begin
                    int tv;
                    tv = int'($urandom_range(0, 12)) - 3;
                    st_t[c][k]   = 32'(tv * 32768);
                    st_idx[c][k] = $urandom;
                end
            end
            st_n = 24;
            run_batch(cnt, 1'($urandom), 1'($urandom));
        end

        repeat (4) @(posedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
